// File: rtl/oc8051_ifetch_buf.sv
// Instruction prefetch buffer between the code ROM and the 8051 decoder.
// It fetches 32-bit ROM words into a circular byte queue and presents a 3-byte opcode window at the PC.
module oc8051_ifetch_buf #(
  parameter int          DEPTH    = 8,
  parameter int          ROM_SIZE = 386,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_req,
  output logic [15:0]              rom_addr,
  input  logic [31:0]              rom_data_in,
  input  logic                     rom_ack,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  input  logic                     op_take,
  input  logic [1:0]               op_len,
  output logic                     op_valid,
  output logic [15:0]              pc_out,
  output logic [7:0]               op0_out,
  output logic [7:0]               op1_out,
  output logic [7:0]               op2_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C0        = (AW+1)'(0);
  localparam logic [AW:0]   C1        = (AW+1)'(1);
  localparam logic [AW:0]   C2        = (AW+1)'(2);
  localparam logic [AW:0]   C3        = (AW+1)'(3);
  localparam logic [AW:0]   C4        = (AW+1)'(4);
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [16:0]   ROM_LIMIT = 17'(ROM_SIZE);
  localparam logic [AW-1:0] P1        = AW'(1);
  localparam logic [AW-1:0] P2        = AW'(2);
  localparam logic [AW-1:0] P4        = AW'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW:0]     count_r;
  logic [15:0]     fetch_ptr_r;
  logic [15:0]     pc_r;

  logic            fetch_ok_s;
  logic            space_ok_s;
  logic            halted_s;
  logic            op_valid_s;
  logic            take_s;
  logic            push_s;
  logic            issue_s;
  logic [AW:0]     len_ext_s;
  logic [AW:0]     popped_s;

  assign fetch_ok_s = ({1'b0, fetch_ptr_r} < ROM_LIMIT);
  assign space_ok_s = ((C_DEPTH - count_r) >= C4);
  assign halted_s   = !fetch_ok_s && (state_r == IDLE);
  assign op_valid_s = (count_r >= C3) || ((count_r != C0) && halted_s);

  assign op_valid  = op_valid_s;
  assign pc_out    = pc_r;
  assign count_out = count_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a DROP keeps the handshake open until the ROM answers
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!redirect && fetch_ok_s && space_ok_s) state_next_s = WAIT;
        else                                       state_next_s = IDLE;
      end
      WAIT: begin
        if (redirect)     state_next_s = rom_ack ? IDLE : DROP;
        else if (rom_ack) state_next_s = IDLE;
        else              state_next_s = WAIT;
      end
      DROP: begin
        if (rom_ack) state_next_s = IDLE;
        else         state_next_s = DROP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: request issue, queue push and decoder pop amount
  always_comb begin
    issue_s   = (state_r == IDLE) && (state_next_s == WAIT);
    push_s    = (state_r == WAIT) && rom_ack && !redirect;
    take_s    = op_take && op_valid_s && (op_len != 2'd0) && !redirect;
    len_ext_s = {{(AW-1){1'b0}}, op_len};
    if (!take_s)                  popped_s = C0;
    else if (len_ext_s > count_r) popped_s = count_r;
    else                          popped_s = len_ext_s;
  end

  // ROM request/address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_req  <= 1'b0;
      rom_addr <= 16'h0000;
    end else begin
      rom_req <= (state_next_s != IDLE);
      if (issue_s) rom_addr <= fetch_ptr_r;
    end
  end

  // Queue pointers, occupancy, PC and fetch pointer; redirect overrides push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= C0;
      pc_r        <= RESET_PC;
      fetch_ptr_r <= RESET_PC;
    end else if (redirect) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= C0;
      pc_r        <= redirect_pc;
      fetch_ptr_r <= redirect_pc;
    end else begin
      if (push_s) begin
        wr_ptr_r    <= wr_ptr_r + P4;
        fetch_ptr_r <= fetch_ptr_r + 16'd4;
      end
      rd_ptr_r <= rd_ptr_r + popped_s[AW-1:0];
      if (take_s) pc_r <= pc_r + {14'd0, op_len};
      count_r <= count_r + (push_s ? C4 : C0) - popped_s;
    end
  end

  // Byte storage; contents beyond count are masked at the window
  always_ff @(posedge clk) begin
    if (push_s) begin
      for (int k = 0; k < 4; k++) begin
        mem_r[wr_ptr_r + AW'(k)] <= rom_data_in[8*k +: 8];
      end
    end
  end

  // Opcode window from the queue head
  always_comb begin
    op0_out = 8'h00;
    op1_out = 8'h00;
    op2_out = 8'h00;
    if (count_r >= C1) op0_out = mem_r[rd_ptr_r];
    else               op0_out = 8'h00;
    if (count_r >= C2) op1_out = mem_r[rd_ptr_r + P1];
    else               op1_out = 8'h00;
    if (count_r >= C3) op2_out = mem_r[rd_ptr_r + P2];
    else               op2_out = 8'h00;
  end

endmodule

// File: tb/tb_oc8051_ifetch_buf.sv
// Directed bench for oc8051_ifetch_buf: one DUT with the default ROM size and a
// second with ROM_SIZE=10; the ROM model returns byte = addr[7:0].
module tb_oc8051_ifetch_buf;
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req, rom_ack, redirect, op_take, op_valid;
  logic [15:0] rom_addr, redirect_pc, pc_out;
  logic [31:0] rom_data_in;
  logic [1:0]  op_len;
  logic [7:0]  op0, op1, op2;
  logic [3:0]  count;
  logic [3:0]  ack_delay, wait_cnt;

  logic        rom_req_b, rom_ack_b, op_take_b, op_valid_b;
  logic [15:0] rom_addr_b, pc_b;
  logic [31:0] rom_data_b;
  logic [1:0]  op_len_b;
  logic [7:0]  op0_b, op1_b, op2_b;
  logic [3:0]  count_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data_in = {rom_addr[7:0] + 8'd3, rom_addr[7:0] + 8'd2, rom_addr[7:0] + 8'd1, rom_addr[7:0]};
  assign rom_ack     = rom_req && (wait_cnt >= ack_delay);
  assign rom_data_b  = {rom_addr_b[7:0] + 8'd3, rom_addr_b[7:0] + 8'd2, rom_addr_b[7:0] + 8'd1, rom_addr_b[7:0]};
  assign rom_ack_b   = rom_req_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= 4'd0;
    else if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 4'd1;
    else                        wait_cnt <= 4'd0;
  end

  oc8051_ifetch_buf dut (
    .clk(clk), .rst(rst), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_data_in(rom_data_in), .rom_ack(rom_ack), .redirect(redirect),
    .redirect_pc(redirect_pc), .op_take(op_take), .op_len(op_len),
    .op_valid(op_valid), .pc_out(pc_out), .op0_out(op0), .op1_out(op1),
    .op2_out(op2), .count_out(count)
  );

  oc8051_ifetch_buf #(.DEPTH(8), .ROM_SIZE(10), .RESET_PC(16'h0000)) dut_b (
    .clk(clk), .rst(rst), .rom_req(rom_req_b), .rom_addr(rom_addr_b),
    .rom_data_in(rom_data_b), .rom_ack(rom_ack_b), .redirect(1'b0),
    .redirect_pc(16'h0000), .op_take(op_take_b), .op_len(op_len_b),
    .op_valid(op_valid_b), .pc_out(pc_b), .op0_out(op0_b), .op1_out(op1_b),
    .op2_out(op2_b), .count_out(count_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect = 1'b0; redirect_pc = 16'h0000; op_take = 1'b0; op_len = 2'd0;
    op_take_b = 1'b0; op_len_b = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ack_delay = 4'd0;
    redirect = 1'b0; redirect_pc = 16'h0000; op_take = 1'b0; op_len = 2'd0;
    op_take_b = 1'b0; op_len_b = 2'd0;
    rst = 1'b1;
    #2;
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b exp 0", rom_req); end
    checks++; if (rom_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got %h exp 0000", rom_addr); end
    checks++; if (op_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", op_valid); end
    checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL reset_pc got %h exp 0000", pc_out); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (op0 !== 8'h00) begin failures++; $display("FAIL reset_op0 got %h exp 00", op0); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_take();
    do_reset();
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0000) begin failures++; $display("FAIL first_req got req=%b addr=%h exp 1/0000", rom_req, rom_addr); end
    tick();
    checks++; if (op_valid !== 1'b1) begin failures++; $display("FAIL first_valid got %b exp 1", op_valid); end
    checks++; if ({op0, op1, op2} !== 24'h000102) begin failures++; $display("FAIL first_window got %h exp 000102", {op0, op1, op2}); end
    checks++; if (pc_out !== 16'h0000 || count !== 4'd4) begin failures++; $display("FAIL first_pc_cnt got %h/%0d exp 0000/4", pc_out, count); end
    op_take = 1'b1; op_len = 2'd1;
    tick();
    checks++; if (pc_out !== 16'h0001 || op0 !== 8'h01) begin failures++; $display("FAIL take1 got pc=%h op0=%h exp 0001/01", pc_out, op0); end
    op_len = 2'd2;
    tick();
    checks++; if (pc_out !== 16'h0003 || op0 !== 8'h03 || count !== 4'd5) begin failures++; $display("FAIL take2 got pc=%h op0=%h cnt=%0d exp 0003/03/5", pc_out, op0, count); end
    op_len = 2'd3;
    tick();
    op_take = 1'b0; op_len = 2'd0;
    checks++; if (pc_out !== 16'h0006 || op0 !== 8'h06 || count !== 4'd2) begin failures++; $display("FAIL take3 got pc=%h op0=%h cnt=%0d exp 0006/06/2", pc_out, op0, count); end
    checks++; if (op_valid !== 1'b0 || op2 !== 8'h00) begin failures++; $display("FAIL short_window got v=%b op2=%h exp 0/00", op_valid, op2); end
    tick();
    tick();
    checks++; if ({op0, op1, op2} !== 24'h060708 || count !== 4'd6 || op_valid !== 1'b1) begin failures++; $display("FAIL wrap_window got %h cnt=%0d v=%b exp 060708/6/1", {op0, op1, op2}, count, op_valid); end
  endtask

  task automatic test_no_take();
    do_reset();
    repeat (6) tick();
    checks++; if (count !== 4'd8 || rom_req !== 1'b0) begin failures++; $display("FAIL full got cnt=%0d req=%b exp 8/0", count, rom_req); end
    op_take = 1'b1; op_len = 2'd3;
    tick();
    op_take = 1'b0;
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL full_take3 got %0d exp 5", count); end
    tick();
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL no_space_req got %b exp 0", rom_req); end
    op_take = 1'b1; op_len = 2'd1;
    tick();
    op_take = 1'b0;
    checks++; if (count !== 4'd4 || rom_req !== 1'b0) begin failures++; $display("FAIL take1_cnt got cnt=%0d req=%b exp 4/0", count, rom_req); end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0008) begin failures++; $display("FAIL space_req got req=%b addr=%h exp 1/0008", rom_req, rom_addr); end
  endtask

  task automatic test_redirect_drop();
    bit seen;
    ack_delay = 4'd3;
    do_reset();
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0000) begin failures++; $display("FAIL slow_req got req=%b addr=%h exp 1/0000", rom_req, rom_addr); end
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    checks++; if (pc_out !== 16'h0100 || op_valid !== 1'b0) begin failures++; $display("FAIL redir_pc got pc=%h v=%b exp 0100/0", pc_out, op_valid); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0000) begin failures++; $display("FAIL drop_hold got req=%b addr=%h exp 1/0000", rom_req, rom_addr); end
      if (rom_ack) begin seen = 1'b1; break; end
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL drop_ack_timeout got no ack exp ack"); end
    tick();
    checks++; if (count !== 4'd0 || rom_req !== 1'b0) begin failures++; $display("FAIL drop_discard got cnt=%0d req=%b exp 0/0", count, rom_req); end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0100) begin failures++; $display("FAIL redir_req got req=%b addr=%h exp 1/0100", rom_req, rom_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rom_ack) begin seen = 1'b1; break; end
      tick();
    end
    tick();
    checks++; if (!seen || op_valid !== 1'b1 || op0 !== 8'h00 || op1 !== 8'h01 || pc_out !== 16'h0100) begin failures++; $display("FAIL redir_fill got ack=%b v=%b op0=%h op1=%h pc=%h exp 1/1/00/01/0100", seen, op_valid, op0, op1, pc_out); end
    ack_delay = 4'd0;
  endtask

  task automatic test_redirect_take_ack();
    do_reset();
    repeat (3) tick();
    checks++; if (rom_req !== 1'b1 || rom_ack !== 1'b1 || rom_addr !== 16'h0004) begin failures++; $display("FAIL setup_req got req=%b ack=%b addr=%h exp 1/1/0004", rom_req, rom_ack, rom_addr); end
    redirect = 1'b1; redirect_pc = 16'h0040; op_take = 1'b1; op_len = 2'd2;
    tick();
    redirect = 1'b0; op_take = 1'b0; op_len = 2'd0;
    checks++; if (pc_out !== 16'h0040 || count !== 4'd0 || op_valid !== 1'b0 || rom_req !== 1'b0) begin failures++; $display("FAIL redir_take got pc=%h cnt=%0d v=%b req=%b exp 0040/0/0/0", pc_out, count, op_valid, rom_req); end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0040) begin failures++; $display("FAIL redir_take_req got req=%b addr=%h exp 1/0040", rom_req, rom_addr); end
    tick();
    checks++; if (op0 !== 8'h40 || pc_out !== 16'h0040 || count !== 4'd4) begin failures++; $display("FAIL redir_take_fill got op0=%h pc=%h cnt=%0d exp 40/0040/4", op0, pc_out, count); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    checks++; if (pc_out !== 16'h0020 || count !== 4'd0) begin failures++; $display("FAIL b2b_pc got pc=%h cnt=%0d exp 0020/0", pc_out, count); end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 16'h0020) begin failures++; $display("FAIL b2b_req got req=%b addr=%h exp 1/0020", rom_req, rom_addr); end
  endtask

  task automatic test_rom_limit();
    int nreq;
    bit reached;
    do_reset();
    nreq = 0;
    reached = 1'b0;
    op_len_b = 2'd1;
    for (int i = 0; i < 80; i++) begin
      if (rom_req_b) begin
        checks++; if (rom_addr_b !== 16'(4 * nreq)) begin failures++; $display("FAIL lim_addr got %h exp %h", rom_addr_b, 16'(4 * nreq)); end
        nreq++;
      end
      if (pc_b == 16'd10) begin reached = 1'b1; break; end
      op_take_b = op_valid_b;
      tick();
    end
    op_take_b = 1'b0;
    checks++; if (!reached) begin failures++; $display("FAIL lim_timeout got pc=%h exp 000a", pc_b); end
    repeat (2) tick();
    checks++; if (nreq !== 3 || rom_req_b !== 1'b0) begin failures++; $display("FAIL lim_nreq got %0d req=%b exp 3/0", nreq, rom_req_b); end
    checks++; if (op_valid_b !== 1'b1 || count_b !== 4'd2 || op0_b !== 8'h0a) begin failures++; $display("FAIL lim_pc10 got v=%b cnt=%0d op0=%h exp 1/2/0a", op_valid_b, count_b, op0_b); end
    op_take_b = 1'b1;
    tick();
    checks++; if (pc_b !== 16'd11 || count_b !== 4'd1 || op_valid_b !== 1'b1 || {op0_b, op1_b, op2_b} !== 24'h0b0000) begin failures++; $display("FAIL lim_pc11 got pc=%h cnt=%0d v=%b win=%h exp 000b/1/1/0b0000", pc_b, count_b, op_valid_b, {op0_b, op1_b, op2_b}); end
    tick();
    op_take_b = 1'b0;
    checks++; if (op_valid_b !== 1'b0 || count_b !== 4'd0 || pc_b !== 16'd12) begin failures++; $display("FAIL lim_empty got v=%b cnt=%0d pc=%h exp 0/0/000c", op_valid_b, count_b, pc_b); end
  endtask

  initial begin
    test_reset();
    test_fill_take();
    test_no_take();
    test_redirect_drop();
    test_redirect_take_ack();
    test_back_to_back();
    test_rom_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oc8051_ifetch_buf.md
Name: oc8051_ifetch_buf

Overview:
- Instruction prefetch buffer that sits directly downstream of the code ROM (cxrom).
- Issues 32-bit word reads to the ROM over a req/ack handshake and queues the returned bytes in a circular byte FIFO.
- Presents a 3-byte opcode window (op0..op2) at the current PC to the decoder. The decoder consumes 1..3 bytes per instruction.
- Supports redirect (branch/jump/interrupt): flushes the queue and drops any in-flight ROM response.

Parameters:
DEPTH, 8, byte capacity of the queue; power of two, >= 8.
ROM_SIZE, 386, byte size of code ROM; no fetch is issued at fetch_ptr >= ROM_SIZE.
RESET_PC, 16'h0000, PC and fetch pointer after reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
rom_req  output  1  registered read request; held high until rom_ack.
rom_addr  output  16  registered byte address of the requested word; stable while rom_req is high.
rom_data_in  input  32  ROM word; byte at rom_addr in [7:0], rom_addr+3 in [31:24]; sampled when rom_ack=1.
rom_ack  input  1  ROM response; counts only while rom_req=1.
redirect  input  1  flush and restart at redirect_pc.
redirect_pc  input  16  new PC.
op_take  input  1  decoder consumes op_len bytes this cycle.
op_len  input  2  bytes consumed (1..3); 0 = no-op.
op_valid  output  1  opcode window valid.
pc_out  output  16  PC of op0.
op0_out, op1_out, op2_out  output  8 each  bytes at pc_out, pc_out+1, pc_out+2; 0 where not present.
count_out  output  log2(DEPTH)+1  current queue occupancy (debug).

Behaviour:
- Reset (async, immediate):
  - rom_req=0, rom_addr=0, op_valid=0, op bytes=0, count=0.
  - pc_out=RESET_PC, fetch_ptr=RESET_PC, rd/wr pointers=0, state=IDLE.
- FSM states:
  - IDLE (no request outstanding).
  - WAIT (request outstanding).
  - DROP (request outstanding, result to be discarded).
- IDLE:
  - If !redirect && fetch_ptr < ROM_SIZE && (DEPTH - count) >= 4: next cycle rom_req=1, rom_addr=fetch_ptr, go WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - rom_ack && !redirect: push 4 bytes, fetch_ptr += 4, rom_req=0, go IDLE.
  - redirect (with or without ack): go DROP if no ack this cycle; otherwise discard the data and go IDLE.
- DROP:
  - rom_req stays 1 and rom_addr is unchanged (handshake is never aborted).
  - On rom_ack: discard the data, rom_req=0, go IDLE.
- Fetch latency and throughput:
  - Minimum one cycle IDLE between requests.
  - Bytes pushed on the ack edge are visible to op_valid in the following cycle.
- op_valid rules:
  - op_valid = (count >= 3) OR (count >= 1 AND fetch halted).
  - "Fetch halted" means fetch_ptr >= ROM_SIZE and state = IDLE.
  - The op window is combinational from the queue head. Bytes at positions >= count read 0.
- Consume:
  - Applies when op_take && op_valid && op_len != 0 && !redirect.
  - Pops min(op_len, count) bytes and sets pc_out += op_len.
  - op_take while !op_valid is ignored.
- Simultaneous push and pop in one cycle: count_next = count + 4 - popped. Pointers wrap modulo DEPTH; no overflow is possible because of the space check.
- Redirect:
  - Highest priority; any push/pop in the same cycle is cancelled.
  - count=0, pointers=0, pc_out=redirect_pc, fetch_ptr=redirect_pc.
  - op_valid=0 in the next cycle.
  - Back-to-back redirects: the last one wins.
- Arithmetic: all 16-bit PC/address arithmetic wraps modulo 2^16. fetch_ptr is a byte address and need not be word-aligned.

Test Plan:
- Reset release, ROM model acks same cycle and returns byte = addr[7:0]: rom_req rises 1 cycle after reset. At the ack edge rom_addr=0x0000. Next cycle op_valid=1, op0/1/2=00/01/02, pc_out=0x0000.
- Take op_len 1, then 2, then 3 on consecutive valid cycles: pc_out = 0x0001, 0x0003, 0x0006; op0 = 01, 03, 06. Bytes are continuous across wrap at DEPTH=8.
- No takes: after two acks count_out=8 and rom_req stays 0. After one take of len 3, count=5 (free 3), still no request. After a further take of len 1, a request to rom_addr 0x0008 issues.
- Ack delayed 3 cycles, redirect to 0x0100 at cycle 1 of the wait: rom_req stays high with rom_addr unchanged until ack. That data is discarded (count stays 0). The next request has rom_addr=0x0100, then op0=0x00, pc_out=0x0100.
- ROM_SIZE=10, consume to pc 10:
  - Requests issue only at 0, 4, 8.
  - At pc 10: op_valid=1, count=2.
  - Take 1: pc 11, count=1, op_valid=1, op1=op2=0.
  - Take 1 again: op_valid=0.
- redirect and op_take(len 2) in the same cycle with rom_ack: pc_out=redirect_pc, count=0, ROM data dropped.
